// File: rtl/contador_bcd_pkg.sv
// Shared types and the BCD step rule for the contador_bcd up/down counter.
// Imported by the counter top, its interface and the testbench.
package contador_bcd_pkg;

  typedef enum logic {
    PARADO   = 1'b0,
    CONTANDO = 1'b1
  } estado_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t dez;
    bcd_t uni;
  } valor_t;

  typedef struct packed {
    valor_t v;
    logic   wrap;
  } step_t;

  // One tick of the two-digit counter.
  // Terminal values wrap and raise the wrap flag.
  function automatic step_t bcd_step(
    input valor_t v,
    input logic   dn,
    input valor_t vmax
  );
    step_t r;
    r.v    = v;
    r.wrap = 1'b0;
    if (!dn) begin
      unique case (1'b1)
        (v == vmax): begin
          r.v    = '0;
          r.wrap = 1'b1;
        end
        (v != vmax && v.uni == 4'd9): begin
          r.v.uni = 4'd0;
          r.v.dez = v.dez + 4'd1;
        end
        default: r.v.uni = v.uni + 4'd1;
      endcase
    end else begin
      unique case (1'b1)
        (v == '0): begin
          r.v    = vmax;
          r.wrap = 1'b1;
        end
        (v != '0 && v.uni == 4'd0): begin
          r.v.uni = 4'd9;
          r.v.dez = v.dez - 4'd1;
        end
        default: r.v.uni = v.uni - 4'd1;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_bcd_if.sv
// Handshake bundle for contador_bcd: controls in, digits/status out.
// master drives the controls, slave is the counter side.
interface contador_bcd_if;
  import contador_bcd_pkg::*;

  logic btn_start;
  logic clr;
  logic down;
  bcd_t unidade;
  bcd_t dezena;
  logic wrap;
  logic running;

  modport master (
    output btn_start,
    output clr,
    output down,
    input  unidade,
    input  dezena,
    input  wrap,
    input  running
  );

  modport slave (
    input  btn_start,
    input  clr,
    input  down,
    output unidade,
    output dezena,
    output wrap,
    output running
  );

endinterface

// File: rtl/contador_bcd_debouncer.sv
// debouncer: level filter, output follows input after N equal samples.
// Only built when CONTADOR_BCD_DEBOUNCE_EN is defined.
`ifdef CONTADOR_BCD_DEBOUNCE_EN
module debouncer #(
  parameter int N = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_TOP = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;

  // Any sample equal to the output restarts the stability run.
  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (din == dout_q) begin
      cnt_d = '0;
    end else if (cnt_q == C_TOP) begin
      dout_d = din;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule
`endif

// File: rtl/contador_bcd.sv
// contador_bcd: start/stop two-digit BCD up/down counter with prescaler.
// Define CONTADOR_BCD_DEBOUNCE_EN to debounce btn_start.
module contador_bcd
  import contador_bcd_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int MAX_VAL    = 59,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start,
  input  logic clr,
  input  logic down,
  output bcd_t unidade,
  output bcd_t dezena,
  output logic wrap,
  output logic running
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_TOP = PW'(DIV - 1);
  localparam valor_t V_MAX = '{
    dez: bcd_t'(MAX_VAL / 10),
    uni: bcd_t'(MAX_VAL % 10)
  };

  logic [1:0]    sync_q, sync_d;
  logic          btn_lvl;
  logic          btn_prev_q, btn_prev_d;
  logic          btn_rise;
  estado_t       state_q, state_d;
  logic          running_q, running_d;
  logic [PW-1:0] presc_q, presc_d;
  valor_t        val_q, val_d;
  logic          wrap_q, wrap_d;
  logic          tick;
  step_t         nxt;

`ifdef CONTADOR_BCD_DEBOUNCE_EN
  debouncer #(
    .N (DEB_CYCLES)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sync_q[1]),
    .dout  (btn_lvl)
  );
`else
  localparam int unused_deb = DEB_CYCLES;
  assign btn_lvl = sync_q[1];
`endif

  always_comb begin
    sync_d     = {sync_q[0], btn_start};
    btn_prev_d = btn_lvl;
    btn_rise   = btn_lvl & ~btn_prev_q;

    state_d = state_q;
    if (btn_rise) begin
      state_d = (state_q == PARADO) ? CONTANDO : PARADO;
    end
    running_d = (state_d == CONTANDO);

    // Prescaler freezes while stopped so a restart resumes the period.
    tick    = (state_q == CONTANDO) && (presc_q == P_TOP);
    presc_d = presc_q;
    if (state_q == CONTANDO) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    nxt    = bcd_step(val_q, down, V_MAX);
    val_d  = val_q;
    wrap_d = 1'b0;
    if (tick) begin
      val_d  = nxt.v;
      wrap_d = nxt.wrap;
    end

    if (clr) begin
      presc_d = '0;
      val_d   = '0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      btn_prev_q <= 1'b0;
      state_q    <= PARADO;
      running_q  <= 1'b0;
      presc_q    <= '0;
      val_q      <= '0;
      wrap_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      btn_prev_q <= btn_prev_d;
      state_q    <= state_d;
      running_q  <= running_d;
      presc_q    <= presc_d;
      val_q      <= val_d;
      wrap_q     <= wrap_d;
    end
  end

  assign unidade = val_q.uni;
  assign dezena  = val_q.dez;
  assign wrap    = wrap_q;
  assign running = running_q;

endmodule

// File: tb/tb_contador_bcd.sv
// Testbench for contador_bcd: directed scenarios plus random stimulus
// against a behavioural model of counter value and button path.
module tb_contador_bcd;
  import contador_bcd_pkg::*;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int MAX_VAL = 12;
  localparam int DEB     = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;
`ifdef CONTADOR_BCD_DEBOUNCE_EN
  localparam int PRESS_LEN = 6;
  localparam int LAT       = 7;
`else
  localparam int PRESS_LEN = 1;
  localparam int LAT       = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  contador_bcd_if bus ();

  contador_bcd #(
    .CLK_HZ     (CLK_HZ),
    .TICK_HZ    (TICK_HZ),
    .MAX_VAL    (MAX_VAL),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (bus.btn_start),
    .clr       (bus.clr),
    .down      (bus.down),
    .unidade   (bus.unidade),
    .dezena    (bus.dezena),
    .wrap      (bus.wrap),
    .running   (bus.running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int val;
    int ph;
    int cnt;
    bit run;
    bit wrap;
    bit s1;
    bit s2;
    bit prev;
    bit lvl;
  } mdl_t;

  mdl_t m = '0;

  function automatic mdl_t nxt(mdl_t c, logic b, logic cl, logic dn);
    mdl_t n;
    bit   e;
    n = c;
`ifdef CONTADOR_BCD_DEBOUNCE_EN
    e = c.lvl & ~c.prev;
    n.prev = c.lvl;
    if (c.s2 == c.lvl) n.cnt = 0;
    else if (c.cnt == DEB - 1) begin
      n.lvl = c.s2;
      n.cnt = 0;
    end else n.cnt = c.cnt + 1;
`else
    e = c.s2 & ~c.prev;
    n.prev = c.s2;
`endif
    n.s2 = c.s1;
    n.s1 = b;
    n.wrap = 1'b0;
    if (cl) begin
      n.val = 0;
      n.ph  = 0;
    end else if (c.run) begin
      if (c.ph == DIV - 1) begin
        n.ph = 0;
        if (!dn) begin
          if (c.val == MAX_VAL) begin
            n.val = 0;
            n.wrap = 1'b1;
          end else n.val = c.val + 1;
        end else begin
          if (c.val == 0) begin
            n.val = MAX_VAL;
            n.wrap = 1'b1;
          end else n.val = c.val - 1;
        end
      end else n.ph = c.ph + 1;
    end
    if (e) n.run = ~c.run;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= nxt(m, bus.btn_start, bus.clr, bus.down);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.dezena !== 4'(m.val / 10) ||
          bus.unidade !== 4'(m.val % 10) ||
          bus.wrap !== m.wrap || bus.running !== m.run) begin
        errors++;
        $display("FAIL model t=%0t got %0d%0d w%0b r%0b expected %0d%0d w%0b r%0b",
                 $time, bus.dezena, bus.unidade, bus.wrap, bus.running,
                 m.val / 10, m.val % 10, m.wrap, m.run);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int val();
    return int'(bus.dezena) * 10 + int'(bus.unidade);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.btn_start = 1'b0;
    bus.clr = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic press(input int len);
    bus.btn_start = 1'b1;
    cyc(len);
    bus.btn_start = 1'b0;
  endtask

  task automatic wait_run(input logic lvl, input string nm);
    int n;
    n = 0;
    while (bus.running !== lvl && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, bus.running, lvl);
  endtask

  int hold;

  initial begin
    bus.btn_start = 1'b0;
    bus.clr = 1'b0;
    bus.down = 1'b0;

    // Up count, wrap pulse, 09 -> 10 carry
    do_reset();
    chk("rst_val", val(), 0);
    chk("rst_run", bus.running, 0);
    chk("rst_wrap", bus.wrap, 0);
    press(PRESS_LEN);
    wait_run(1'b1, "start");
    chk("k0_val", val(), 0);
    cyc(10);
    chk("k10_val", val(), 1);
    cyc(80);
    chk("k90_val", val(), 9);
    cyc(10);
    chk("k100_dez", bus.dezena, 1);
    chk("k100_uni", bus.unidade, 0);
    cyc(29);
    chk("k129_val", val(), 12);
    cyc(1);
    chk("k130_val", val(), 0);
    chk("k130_wrap", bus.wrap, 1);
    cyc(1);
    chk("k131_wrap", bus.wrap, 0);

    // Down from 00 wraps to MAX_VAL
    bus.down = 1'b1;
    do_reset();
    press(PRESS_LEN);
    wait_run(1'b1, "start_dn");
    cyc(10);
    chk("dn_val", val(), 12);
    chk("dn_wrap", bus.wrap, 1);
    cyc(1);
    chk("dn_wrap_off", bus.wrap, 0);
    cyc(9);
    chk("dn_val2", val(), 11);
    bus.down = 1'b0;

    // Stop with prescaler at 3, resume finishes the period
    do_reset();
    press(PRESS_LEN);
    wait_run(1'b1, "start_st");
    cyc(13 - LAT);
    press(PRESS_LEN);
    wait_run(1'b0, "stop");
    chk("stop_val", val(), 1);
    cyc(50);
    chk("hold_val", val(), 1);
    press(PRESS_LEN);
    wait_run(1'b1, "resume");
    cyc(6);
    chk("res6_val", val(), 1);
    cyc(1);
    chk("res7_val", val(), 2);

    // clr on the wrapping tick
    do_reset();
    press(PRESS_LEN);
    wait_run(1'b1, "start_clr");
    cyc(129);
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
    chk("clr_val", val(), 0);
    chk("clr_wrap", bus.wrap, 0);
    chk("clr_run", bus.running, 1);
    cyc(10);
    chk("clr_next", val(), 1);

    // Asynchronous reset mid-count
    cyc(23);
    rst_n = 1'b0;
    #1;
    chk("arst_val", val(), 0);
    chk("arst_run", bus.running, 0);
    chk("arst_wrap", bus.wrap, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

`ifdef CONTADOR_BCD_DEBOUNCE_EN
    press(2);
    cyc(20);
    chk("glitch", bus.running, 0);
    press(6);
    wait_run(1'b1, "deb_press");
`else
    press(1);
    wait_run(1'b1, "short_press");
`endif
    cyc(20);

    // Random stimulus against the model
    do_reset();
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold > 0) hold--;
      else if ($urandom_range(0, 29) == 0) hold = $urandom_range(1, 10);
      bus.btn_start = (hold > 0);
      bus.clr = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 39) == 0) bus.down = ~bus.down;
      rst_n = ($urandom_range(0, 1999) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_bcd.md
CONTADOR_BCD -- requirements
Module: contador_bcd

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, count rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 Parameter MAX_VAL, default 59, terminal count, legal range 1..99.
REQ-004 Parameter DEB_CYCLES, default 500_000, debounce stable-time in clk cycles, used only with the macro.
REQ-005 Port clk  input  1  single system clock, rising-edge active.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port btn_start  input  1  start/stop pushbutton, active-high, asynchronous to clk.
REQ-008 Port clr  input  1  synchronous clear, active-high, level.
REQ-009 Port down  input  1  count direction: 0 counts up, 1 counts down; sampled only on a tick.
REQ-010 Port unidade  output  4  BCD units digit, feeds the 7-segment decoder.
REQ-011 Port dezena  output  4  BCD tens digit, feeds the 7-segment decoder.
REQ-012 Port wrap  output  1  one-cycle pulse on terminal-count wrap.
REQ-013 Port running  output  1  high while in state CONTANDO.

Function
REQ-014 States SHALL be PARADO and CONTANDO; a rising edge of the conditioned button SHALL toggle the state, taking effect one clk after the edge is detected.
REQ-015 The prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 only in CONTANDO, producing an internal tick in the cycle it reaches its top value, then restarting at 0.
REQ-016 In PARADO the prescaler SHALL hold its value, so resuming continues the partial period.
REQ-017 Up tick: value==MAX_VAL -> 00 with wrap=1; unidade==9 -> unidade 0, dezena+1; otherwise unidade+1.
REQ-018 Down tick: value==00 -> MAX_VAL with wrap=1; unidade==0 -> unidade 9, dezena-1; otherwise unidade-1.
REQ-019 unidade and dezena SHALL be registered and always hold 0..9; the value SHALL never exceed MAX_VAL.
REQ-020 wrap SHALL be high exactly one cycle, the cycle after the wrapping tick, registered alongside the digits.
REQ-021 clr SHALL zero digits and prescaler and suppress any same-cycle tick and wrap; the state is unchanged.
REQ-022 A button edge coincident with clr SHALL still toggle the state.
REQ-023 A change of down mid-period SHALL affect only the next tick.

Reset
REQ-024 rst_n low SHALL immediately force: state PARADO, unidade 0, dezena 0, prescaler 0, wrap 0, running 0, and all edge/synchronizer/debounce registers 0.
REQ-025 A reset asserted mid-count SHALL discard the count; release SHALL resume in PARADO at 00.

Configuration
REQ-026 With CONTADOR_BCD_DEBOUNCE_EN defined, btn_start SHALL pass a 2-flop synchronizer and a debouncer requiring DEB_CYCLES consecutive stable samples before the conditioned level changes.
REQ-027 Without CONTADOR_BCD_DEBOUNCE_EN, btn_start SHALL pass only the 2-flop synchronizer; DEB_CYCLES is ignored.
REQ-028 Edge detection SHALL follow the conditioned level in both builds.

Structure
REQ-029 Package contador_bcd_pkg SHALL hold typedef estado_t (PARADO, CONTANDO) and typedef bcd_t (logic [3:0]).
REQ-030 The debouncer SHALL be a sub-module named debouncer, instantiated only under CONTADOR_BCD_DEBOUNCE_EN.

Verification (CLK_HZ=10, TICK_HZ=1, MAX_VAL=12, DEB_CYCLES=4)
REQ-031 Reset, press btn, up, 130 cycles -> digits step every 10 cycles 00..12, then 00 with wrap=1 for one cycle.
REQ-032 Count to 09, next tick -> dezena=1, unidade=0.
REQ-033 down=1 from 00, one tick -> digits 12, wrap pulse; next tick -> 11.
REQ-034 Stop 3 cycles into a period, wait 50, restart -> next tick 7 cycles after restart, value unchanged while stopped.
REQ-035 clr on the tick cycle at value 12 -> 00, no wrap, running unchanged; rst_n low mid-count -> all outputs 0 immediately.
REQ-036 Macro defined: 2-cycle btn glitch -> no toggle; 6-cycle press -> one toggle; macro undefined: 1-cycle press -> toggle.
